// File: rtl/rev_pkg.sv
// ============================================================================
// Module      : rev_pkg
// Description : Shared types, constants and sizing helper for stream_reverser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rev_pkg;

  // Frame FSM encoding: collect elements, then emit them.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Frame order selection, sampled on the first element of each frame.
  localparam logic MODE_REV  = 1'b0;
  localparam logic MODE_PASS = 1'b1;

  // Number of bits needed to hold any value in 0..n (minimum 1).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << w) <= longint'(n)) begin
        w = w + 1;
      end
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_reverser_if.sv
// ============================================================================
// Module      : stream_reverser_if
// Description : Upstream/downstream handshake bundle for stream_reverser.
//               The slave modport is the reverser's view of the bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_reverser_if #(
  parameter int WIDTH = 8
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/rev_buf.sv
// ============================================================================
// Module      : rev_buf
// Description : N x WIDTH frame store; one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rev_buf #(
  parameter int N     = 5,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [N];

  // Store one element per accepted input transfer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/stream_reverser.sv
// ============================================================================
// Module      : stream_reverser
// Description : Collects a frame of up to N elements, then emits it either
//               reversed or in original order. No fill/drain overlap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_reverser
  import rev_pkg::*;
#(
  parameter int N     = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_reverser_if.slave s
);

  // Indices cover 0..N-1; the frame length needs to reach N.
  localparam int             IW       = idx_width(N - 1);
  localparam int             LW       = idx_width(N);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic [LW-1:0]    len_q, len_d;
  logic             mode_q, mode_d;
  logic             en_q;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_frame_mode;
  logic             w_close;
  logic             w_out_last;
  logic [WIDTH-1:0] w_rd_data;

  // in_ready stays low through reset and rises on the first edge after it.
  assign s.in_ready  = en_q && (state_q == FILL);
  assign s.out_valid = (state_q == DRAIN);
  assign s.busy      = (state_q == DRAIN);

  assign w_out_last  = (state_q == DRAIN) &&
                       ((mode_q == MODE_PASS) ? (LW'(rd_idx_q) == (len_q - LW'(1)))
                                              : (rd_idx_q == '0));
  assign s.out_last  = w_out_last;
  assign s.out_data  = rst_n ? w_rd_data : '0;

  assign w_in_xfer   = s.in_valid && s.in_ready;
  assign w_out_xfer  = s.out_valid && s.out_ready;
  // The first element of a frame takes the live mode; later ones the latched.
  assign w_frame_mode = (wr_cnt_q == '0) ? s.mode : mode_q;
  assign w_close     = w_in_xfer && (s.in_last || (wr_cnt_q == LAST_IDX));

  rev_buf #(
    .N     (N),
    .WIDTH (WIDTH),
    .AW    (IW)
  ) u_buf (
    .clk     (clk),
    .we_i    (w_in_xfer),
    .waddr_i (wr_cnt_q),
    .wdata_i (s.in_data),
    .raddr_i (rd_idx_q),
    .rdata_o (w_rd_data)
  );

  // State, counters and latched frame attributes; reset discards any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      len_q    <= '0;
      mode_q   <= MODE_REV;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      en_q     <= 1'b1;
    end
  end

  // Next-state: accept until the frame closes, then walk the buffer out.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    len_d    = len_q;
    mode_d   = mode_q;
    case (state_q)
      FILL: begin
        if (w_in_xfer) begin
          mode_d = w_frame_mode;
          if (w_close) begin
            state_d  = DRAIN;
            len_d    = LW'(wr_cnt_q) + LW'(1);
            rd_idx_d = (w_frame_mode == MODE_PASS) ? '0 : wr_cnt_q;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (w_out_xfer) begin
          if (w_out_last) begin
            state_d = FILL;
          end else if (mode_q == MODE_PASS) begin
            rd_idx_d = rd_idx_q + 1'b1;
          end else begin
            rd_idx_d = rd_idx_q - 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_reverser.sv
// ============================================================================
// Module      : tb_stream_reverser
// Description : Self-checking bench for stream_reverser (N=5, WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_reverser;

  localparam int N = 5;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  stream_reverser_if #(.WIDTH(W)) bus ();

  stream_reverser #(
    .N     (N),
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fr [N];
  logic [W-1:0] exp_q [$];
  bit           last_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Push one frame in; the model records what must come out.
  task automatic send_frame(input int flen, input bit fmode, input bit use_last,
                            input bit flip, input bit gaps);
    int guard;
    for (int i = 0; i < flen; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("gap_out_valid", bus.out_valid, 0);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = fr[i];
      bus.in_last  = use_last && (i == flen - 1);
      if (i == 0)     bus.mode = fmode;
      else if (flip)  bus.mode = (i >= 2) ? ~fmode : fmode;
      else            bus.mode = 1'($urandom_range(0, 1));
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("in_ready_wait", bus.in_ready, 1);
      chk("fill_out_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("latency_out_valid", bus.out_valid, 1);
    chk("drain_in_ready", bus.in_ready, 0);
    for (int k = 0; k < flen; k++) begin
      exp_q.push_back(fmode ? fr[k] : fr[flen - 1 - k]);
      last_q.push_back(k == flen - 1);
    end
  endtask

  // Pull up to nmax elements out, checking each presented element.
  task automatic drain(input int nmax, input bit rnd, input int stall, input bit hold);
    int n;
    int guard;
    int st;
    n = 0;
    guard = 0;
    st = stall;
    while (exp_q.size() > 0 && n < nmax && guard < 200) begin
      if (st > 0) begin
        bus.out_ready = 1'b0;
        st--;
      end else begin
        bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (hold) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        bus.in_last  = 1'b0;
        chk("hold_in_ready", bus.in_ready, 0);
      end
      chk("out_valid", bus.out_valid, 1);
      chk("busy", bus.busy, 1);
      chk("out_data", bus.out_data, exp_q[0]);
      chk("out_last", bus.out_last, last_q[0]);
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
        n++;
      end
      @(negedge clk);
      guard++;
    end
    chk("drain_progress", (exp_q.size() == 0) || (n >= nmax), 1);
    bus.out_ready = 1'b0;
    if (exp_q.size() == 0) begin
      chk("refill_in_ready", bus.in_ready, 1);
      chk("refill_out_valid", bus.out_valid, 0);
      chk("idle_busy", bus.busy, 0);
    end
  endtask

  initial begin
    int  flen;
    bit  ul;
    bit  m;

    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre_edge", bus.in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);

    // Full-length reverse.
    for (int i = 0; i < N; i++) fr[i] = 8'(i + 1);
    send_frame(5, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(99, 1'b0, 0, 1'b0);

    // Short frame closed by in_last.
    fr[0] = 8'd7; fr[1] = 8'd8; fr[2] = 8'd9;
    send_frame(3, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(99, 1'b0, 0, 1'b0);

    // Pass-through with mode flipped mid-frame.
    for (int i = 0; i < N; i++) fr[i] = 8'(10 + i);
    send_frame(5, 1'b1, 1'b0, 1'b1, 1'b0);
    drain(99, 1'b0, 0, 1'b0);

    // Backpressure on the first output, input held during drain.
    for (int i = 0; i < N; i++) fr[i] = 8'(i + 1);
    send_frame(5, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(99, 1'b0, 3, 1'b1);
    fr[0] = 8'hEE; fr[1] = 8'h31; fr[2] = 8'h32;
    send_frame(3, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(99, 1'b0, 0, 1'b0);

    // Single-element frames in both modes.
    fr[0] = 8'hAA;
    send_frame(1, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(99, 1'b0, 0, 1'b0);
    send_frame(1, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(99, 1'b0, 0, 1'b0);

    // Reset in the middle of a drain.
    for (int i = 0; i < N; i++) fr[i] = 8'(i + 1);
    send_frame(5, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(2, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_last", bus.out_last, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    exp_q.delete();
    last_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_pre_edge", bus.in_ready, 0);
    @(negedge clk);
    chk("mid_rel_in_ready", bus.in_ready, 1);
    fr[0] = 8'd20; fr[1] = 8'd21;
    send_frame(2, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(99, 1'b0, 0, 1'b0);

    // Randomized frames with random gaps and downstream stalls.
    repeat (40) begin
      flen = $urandom_range(1, N);
      ul   = (flen < N) ? 1'b1 : 1'($urandom_range(0, 1));
      m    = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
      send_frame(flen, m, ul, 1'b0, 1'b1);
      drain(99, 1'b1, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_reverser.md
STREAM_REVERSER -- requirements
Module: stream_reverser

Interface
REQ-001 Parameter N, default 5, frame depth in elements; legal range 2..256.
REQ-002 Parameter WIDTH, default 8, element width in bits; legal range 1..64.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mode  input  1  frame order: 0 = reverse, 1 = pass-through (original order).
REQ-006 in_valid  input  1  upstream element present.
REQ-007 in_ready  output  1  block accepts an element this cycle.
REQ-008 in_data  input  WIDTH  upstream element.
REQ-009 in_last  input  1  marks the final element of a short frame.
REQ-010 out_valid  output  1  downstream element present.
REQ-011 out_ready  input  1  downstream accepts the element.
REQ-012 out_data  output  WIDTH  downstream element.
REQ-013 out_last  output  1  marks the final element of the output frame.
REQ-014 busy  output  1  high while the block is in DRAIN.

Function
REQ-015 The FSM SHALL have exactly two states, FILL and DRAIN; reset enters FILL.
REQ-016 Transfer rule: an input transfer occurs on in_valid && in_ready; an output transfer occurs on out_valid && out_ready.
REQ-017 FILL behaviour:
- in_ready = 1, out_valid = 0.
- Each input transfer writes buf[wr_cnt] and increments wr_cnt.
REQ-018 Mode latch: mode is sampled on the first input transfer of a frame and held for the whole frame; mode changes mid-frame have no effect.
REQ-019 Frame close: the frame closes on an input transfer with in_last = 1, or on the transfer that writes index N-1 (in_last ignored there).
- Latch len = wr_cnt + 1.
- Next cycle: DRAIN.
REQ-020 DRAIN behaviour:
- in_ready = 0, out_valid = 1, busy = 1.
- out_data = buf[rd_idx].
- rd_idx starts at len-1 and decrements when reversing.
- rd_idx starts at 0 and increments in pass-through.
REQ-021 rd_idx and out_data SHALL hold while out_valid && !out_ready.
REQ-022 out_last = 1 exactly when the current element is the final element of the frame (rd_idx 0 when reversing, len-1 in pass-through).
REQ-023 DRAIN exit: the output transfer with out_last returns the FSM to FILL on the next cycle with wr_cnt = 0; in_ready rises that cycle.
- There is no fill/drain overlap.
REQ-024 Latency: first out_valid occurs one cycle after the closing input transfer.
- Minimum frame period is 2*len cycles.
REQ-025 A one-element frame (in_last on the first transfer) SHALL emit that element with out_last = 1 in both modes.
REQ-026 Input held during DRAIN: in_valid asserted during DRAIN SHALL be stalled (in_ready = 0) and never dropped or written.
REQ-027 Buffer contents are not cleared between frames; stale entries beyond len SHALL never appear on out_data.

Reset
REQ-028 rst_n low SHALL asynchronously force the following, regardless of state, and discard any partial frame:
- FSM = FILL, wr_cnt = 0, rd_idx = 0, len = 0, latched mode = 0.
- Outputs: in_ready = 0, out_valid = 0, out_last = 0, busy = 0.
REQ-029 out_data is 0 while rst_n is low; buffer contents are not reset.
REQ-030 in_ready SHALL rise on the first rising clock edge after rst_n deasserts.

Structure
REQ-031 Shared package rev_pkg SHALL hold:
- the state encoding (FILL = 0, DRAIN = 1);
- the mode constants MODE_REV = 0 and MODE_PASS = 1;
- a clog2-style index-width function used for wr_cnt, rd_idx and len.
REQ-032 Storage SHALL be one sub-module, rev_buf: N x WIDTH register array, one synchronous write port, one asynchronous read port, no reset.
REQ-033 FSM, counters and handshake logic reside in stream_reverser.

Verification (N=5, WIDTH=8)
REQ-034 Full reverse: mode 0, inputs 1,2,3,4,5 with no in_last, out_ready = 1 -> outputs 5,4,3,2,1; out_last only on 5; out_valid first seen one cycle after the transfer of 5.
REQ-035 Short frame: mode 0, inputs 7,8,9 with in_last on 9 -> outputs 9,8,7; out_last on 7; in_ready back high the cycle after 7 transfers.
REQ-036 Pass-through with a mode flip: mode 1 at the first transfer, mode toggled to 0 after the second, inputs 10..14 -> outputs 10,11,12,13,14.
REQ-037 Backpressure: out_ready low for 3 cycles while 5 is presented -> out_data stays 5 and out_valid stays 1 throughout; in_valid held high during DRAIN sees in_ready = 0 and nothing is lost; the next frame starts only after out_last transfers.
REQ-038 Reset mid-drain: rst_n pulsed low after 5,4 are emitted -> out_valid and busy drop immediately; after release in_ready = 1; a new frame 20,21 with in_last emits 21,20.
REQ-039 Single element: in_last on the first input 0xAA -> one output 0xAA with out_last = 1, in both mode 0 and mode 1.
